// File: rtl/cpu_pkg.sv
// Shared load-path types: sub-op codes, ROB tag sentinel, load-unit FSM states and the
// latched load request payload.
package cpu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned SUB_W  = 3;

    localparam logic [6:0]       LOAD_OP     = 7'b0000011;
    localparam logic [ROB_W-1:0] INVALID_ROB = 6'd16;

    localparam logic [SUB_W-1:0] SUB_LB  = 3'b000;
    localparam logic [SUB_W-1:0] SUB_LH  = 3'b001;
    localparam logic [SUB_W-1:0] SUB_LW  = 3'b010;
    localparam logic [SUB_W-1:0] SUB_LBU = 3'b100;
    localparam logic [SUB_W-1:0] SUB_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BCAST = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
        logic [SUB_W-1:0]  sub;
    } load_req_t;

    // Unlisted sub-op codes behave as LW, so they inherit the word alignment rule.
    function automatic logic is_misaligned(input logic [SUB_W-1:0] sub, input logic [1:0] lo);
        case (sub)
            SUB_LB, SUB_LBU: return 1'b0;
            SUB_LH, SUB_LHU: return lo[0];
            default:         return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_mem_unit_if.sv
// Load unit bus bundle: RS issue handshake, flush, data-memory read port and CDB slot.
interface load_mem_unit_if;
    import cpu_pkg::*;

    logic              loadEnable;
    logic [ADDR_W-1:0] addr_in;
    logic [ROB_W-1:0]  robNum_in;
    logic [SUB_W-1:0]  subType_in;
    logic              busy;
    logic              flush;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              cdbReq;
    logic              cdbGrant;
    logic              cdbIscast;
    logic [DATA_W-1:0] cdbData;
    logic [ROB_W-1:0]  cdbRobNum;
    logic              cdbExc;

    modport master (
        input  loadEnable, addr_in, robNum_in, subType_in, flush,
        input  mem_ready, mem_rdata, cdbGrant,
        output busy, mem_req, mem_addr,
        output cdbReq, cdbIscast, cdbData, cdbRobNum, cdbExc
    );

    modport slave (
        output loadEnable, addr_in, robNum_in, subType_in, flush,
        output mem_ready, mem_rdata, cdbGrant,
        input  busy, mem_req, mem_addr,
        input  cdbReq, cdbIscast, cdbData, cdbRobNum, cdbExc
    );

endinterface

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module load_align
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        lane,
    input  logic [SUB_W-1:0]  sub_type,
    output logic [DATA_W-1:0] value_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata[7:0];
        half_v  = lane[1] ? rdata[31:16] : rdata[15:0];
        value_c = rdata;
        case (lane)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        case (sub_type)
            SUB_LB:  value_c = {{(DATA_W-8){byte_v[7]}}, byte_v};
            SUB_LH:  value_c = {{(DATA_W-16){half_v[15]}}, half_v};
            SUB_LBU: value_c = {{(DATA_W-8){1'b0}}, byte_v};
            SUB_LHU: value_c = {{(DATA_W-16){1'b0}}, half_v};
            default: value_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_mem_unit.sv
// Single-entry load unit: RS issue -> word read -> align/extend -> CDB broadcast.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned LH/LHU/LW skip memory and broadcast cdbExc=1.
module load_mem_unit
    import cpu_pkg::*;
(
    input logic             clock,
    input logic             reset,
    load_mem_unit_if.master lsu
);

    lsu_state_t        state_q, state_d;
    load_req_t         req_q;
    logic              squash_q, squash_d;
    logic              mis_q, mis_d, mis_new_c;
    logic              issue_c;
    logic              busy_q, mem_req_q, cdb_req_q, cdb_exc_q;
    logic [DATA_W-1:0] data_q, align_c;

`ifdef LOAD_MISALIGN_TRAP_EN
    assign mis_new_c = is_misaligned(lsu.subType_in, lsu.addr_in[1:0]);
`else
    assign mis_new_c = 1'b0;
`endif

    load_align u_align (
        .rdata    (lsu.mem_rdata),
        .lane     (req_q.addr[1:0]),
        .sub_type (req_q.sub),
        .value_c  (align_c)
    );

    // Next state; a squashed or untagged load still finishes its memory handshake.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        mis_d    = mis_q;
        issue_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu.loadEnable && !lsu.flush) begin
                    issue_c  = 1'b1;
                    squash_d = 1'b0;
                    mis_d    = mis_new_c;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (mis_q || lsu.mem_ready) begin
                    if (lsu.flush || squash_q || req_q.rob == INVALID_ROB) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BCAST;
                    end
                end else begin
                    squash_d = squash_q | lsu.flush;
                    state_d  = ST_WAIT;
                end
            end
            ST_BCAST: begin
                if (lsu.flush || lsu.cdbGrant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '{addr: '0, rob: INVALID_ROB, sub: SUB_LW};
            squash_q  <= 1'b0;
            mis_q     <= 1'b0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            cdb_req_q <= 1'b0;
            cdb_exc_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            squash_q  <= squash_d;
            mis_q     <= mis_d;
            busy_q    <= state_d != ST_IDLE;
            mem_req_q <= (state_d == ST_REQ || state_d == ST_WAIT) && !mis_d;
            cdb_req_q <= state_d == ST_BCAST;
            cdb_exc_q <= (state_d == ST_BCAST) && mis_q;
            if (issue_c) begin
                req_q <= '{addr: lsu.addr_in, rob: lsu.robNum_in, sub: lsu.subType_in};
            end
            // Result is frozen on entry to BCAST; a trapped load broadcasts zero.
            if (state_d == ST_BCAST && state_q != ST_BCAST) begin
                data_q <= mis_q ? '0 : align_c;
            end
        end
    end

    assign lsu.busy      = busy_q;
    assign lsu.mem_req   = mem_req_q;
    assign lsu.mem_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
    assign lsu.cdbReq    = cdb_req_q;
    assign lsu.cdbIscast = (state_q == ST_BCAST) && lsu.cdbGrant && !lsu.flush;
    assign lsu.cdbData   = data_q;
    assign lsu.cdbRobNum = req_q.rob;
    assign lsu.cdbExc    = cdb_exc_q;

endmodule

// File: tb/tb_load_mem_unit.sv
// Directed bench for load_mem_unit: alignment, memory wait, CDB stall, flush, tag guard, reset.
module tb_load_mem_unit;
    import cpu_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    load_mem_unit_if bus();

    load_mem_unit dut (
        .clock (clock),
        .reset (reset),
        .lsu   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] s, input logic [5:0] r);
        bus.loadEnable = 1'b1;
        bus.addr_in    = a;
        bus.subType_in = s;
        bus.robNum_in  = r;
        tick();
        bus.loadEnable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.cdbReq !== 1'b0) begin n_fail++; $display("FAIL reset_cdbReq: got %0b want 0", bus.cdbReq); end
        n_checks++; if (bus.cdbIscast !== 1'b0) begin n_fail++; $display("FAIL reset_cdbIscast: got %0b want 0", bus.cdbIscast); end
        n_checks++; if (bus.cdbExc !== 1'b0) begin n_fail++; $display("FAIL reset_cdbExc: got %0b want 0", bus.cdbExc); end
        n_checks++; if (bus.cdbData !== 32'h0) begin n_fail++; $display("FAIL reset_cdbData: got %h want 0", bus.cdbData); end
        n_checks++; if (bus.cdbRobNum !== 6'd16) begin n_fail++; $display("FAIL reset_cdbRobNum: got %0d want 16", bus.cdbRobNum); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_lb_sign();
        issue(32'h103, 3'b000, 6'd5);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lb_busy: got %0b want 1", bus.busy); end
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL lb_mem_req: got %0b want 1", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_mem_addr: got %h want 100", bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h80AA_BBCC;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.cdbReq !== 1'b1) begin n_fail++; $display("FAIL lb_cdbReq: got %0b want 1", bus.cdbReq); end
        n_checks++; if (bus.cdbData !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_cdbData: got %h want ffffff80", bus.cdbData); end
        n_checks++; if (bus.cdbRobNum !== 6'd5) begin n_fail++; $display("FAIL lb_cdbRobNum: got %0d want 5", bus.cdbRobNum); end
        bus.cdbGrant = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b1) begin n_fail++; $display("FAIL lb_iscast: got %0b want 1", bus.cdbIscast); end
        tick();
        bus.cdbGrant = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lb_busy_after: got %0b want 0", bus.busy); end
    endtask

    task automatic test_lhu_zero_wait();
        issue(32'h102, 3'b101, 6'd7);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h8001_1234;
        bus.cdbGrant  = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b0) begin n_fail++; $display("FAIL lhu_iscast_early: got %0b want 0", bus.cdbIscast); end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b1) begin n_fail++; $display("FAIL lhu_iscast_2cyc: got %0b want 1", bus.cdbIscast); end
        n_checks++; if (bus.cdbData !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_cdbData: got %h want 00008001", bus.cdbData); end
        tick();
        bus.cdbGrant = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lhu_busy_after: got %0b want 0", bus.busy); end
    endtask

    task automatic test_lw_wait();
        issue(32'h200, 3'b010, 6'd9);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
                n_fail++; $display("FAIL lw_wait_hold[%0d]: got req=%0b addr=%h want req=1 addr=200", i, bus.mem_req, bus.mem_addr);
            end
            bus.loadEnable = 1'b1;
            bus.addr_in    = 32'h998;
            bus.robNum_in  = 6'd33;
            tick();
        end
        bus.loadEnable = 1'b0;
        n_checks++; if (bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL lw_ignore_issue: got %h want 200", bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_mem_req_drop: got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.cdbData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_cdbData: got %h want deadbeef", bus.cdbData); end
        n_checks++; if (bus.cdbRobNum !== 6'd9) begin n_fail++; $display("FAIL lw_cdbRobNum: got %0d want 9", bus.cdbRobNum); end
        bus.cdbGrant = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b1) begin n_fail++; $display("FAIL lw_iscast: got %0b want 1", bus.cdbIscast); end
        tick();
        bus.cdbGrant = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.cdbIscast !== 1'b0) begin
            n_fail++; $display("FAIL lw_done: got busy=%0b iscast=%0b want 0 0", bus.busy, bus.cdbIscast);
        end
    endtask

    task automatic test_flush_wait();
        issue(32'h300, 3'b010, 6'd10);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_keep_req: got %0b want 1", bus.mem_req); end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        tick();
        bus.mem_ready = 1'b0;
        bus.cdbGrant  = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b0 || bus.cdbReq !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_bcast: got iscast=%0b req=%0b want 0 0", bus.cdbIscast, bus.cdbReq);
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %0b want 0", bus.busy); end
        bus.cdbGrant = 1'b0;
        issue(32'h104, 3'b100, 6'd11);
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104) begin
            n_fail++; $display("FAIL flush_next_accept: got req=%0b addr=%h want 1 104", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1122_33C4;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.cdbData !== 32'h0000_00C4) begin n_fail++; $display("FAIL lbu_cdbData: got %h want 000000c4", bus.cdbData); end
        bus.cdbGrant = 1'b1;
        tick();
        bus.cdbGrant = 1'b0;
    endtask

    task automatic test_grant_stall();
        int casts;
        casts = 0;
        issue(32'h20A, 3'b001, 6'd12);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hF00D_0123;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.cdbData !== 32'hFFFF_F00D) begin n_fail++; $display("FAIL lh_cdbData: got %h want fffff00d", bus.cdbData); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.cdbReq !== 1'b1) begin n_fail++; $display("FAIL stall_req_hold[%0d]: got %0b want 1", i, bus.cdbReq); end
            if (bus.cdbIscast === 1'b1) casts++;
            tick();
        end
        bus.cdbGrant = 1'b1;
        #1;
        if (bus.cdbIscast === 1'b1) casts++;
        tick();
        bus.cdbGrant = 1'b0;
        #1;
        if (bus.cdbIscast === 1'b1) casts++;
        n_checks++; if (casts != 1) begin n_fail++; $display("FAIL stall_one_cast: got %0d casts want 1", casts); end
        n_checks++; if (bus.cdbReq !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop: got %0b want 0", bus.cdbReq); end

        issue(32'h20C, 3'b010, 6'd13);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_CAFE;
        tick();
        bus.mem_ready = 1'b0;
        bus.cdbGrant  = 1'b1;
        bus.flush     = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b0) begin n_fail++; $display("FAIL flush_beats_grant: got %0b want 0", bus.cdbIscast); end
        tick();
        bus.cdbGrant = 1'b0;
        bus.flush    = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.cdbReq !== 1'b0) begin
            n_fail++; $display("FAIL bcast_flush_idle: got busy=%0b req=%0b want 0 0", bus.busy, bus.cdbReq);
        end
    endtask

    task automatic test_invalid_tag();
        issue(32'h400, 3'b010, 6'd16);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL tag_mem_req: got %0b want 1", bus.mem_req); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ready = 1'b0;
        bus.cdbGrant  = 1'b1;
        #1;
        n_checks++; if (bus.cdbReq !== 1'b0 || bus.cdbIscast !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL tag_skip: got req=%0b iscast=%0b busy=%0b want 0 0 0", bus.cdbReq, bus.cdbIscast, bus.busy);
        end
        bus.cdbGrant = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        issue(32'h500, 3'b010, 6'd20);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.cdbReq !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got busy=%0b req=%0b cdbReq=%0b want 0 0 0", bus.busy, bus.mem_req, bus.cdbReq);
        end
        n_checks++; if (bus.cdbData !== 32'h0 || bus.cdbRobNum !== 6'd16) begin
            n_fail++; $display("FAIL rst_mid_data: got data=%h rob=%0d want 0 16", bus.cdbData, bus.cdbRobNum);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.cdbReq !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_bcast: got req=%0b busy=%0b want 0 0", bus.cdbReq, bus.busy);
        end
    endtask

    task automatic test_misalign();
        issue(32'h102, 3'b010, 6'd21);
`ifdef LOAD_MISALIGN_TRAP_EN
        n_checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL mis_no_mem: got req=%0b busy=%0b want 0 1", bus.mem_req, bus.busy);
        end
        tick();
        n_checks++; if (bus.cdbReq !== 1'b1 || bus.cdbExc !== 1'b1 || bus.cdbData !== 32'h0) begin
            n_fail++; $display("FAIL mis_trap: got req=%0b exc=%0b data=%h want 1 1 0", bus.cdbReq, bus.cdbExc, bus.cdbData);
        end
`else
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL mis_mem: got req=%0b addr=%h want 1 100", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++; if (bus.cdbReq !== 1'b1 || bus.cdbExc !== 1'b0 || bus.cdbData !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mis_ignored: got req=%0b exc=%0b data=%h want 1 0 cafef00d", bus.cdbReq, bus.cdbExc, bus.cdbData);
        end
`endif
        bus.cdbGrant = 1'b1;
        #1;
        n_checks++; if (bus.cdbIscast !== 1'b1 || bus.cdbRobNum !== 6'd21) begin
            n_fail++; $display("FAIL mis_cast: got iscast=%0b rob=%0d want 1 21", bus.cdbIscast, bus.cdbRobNum);
        end
        tick();
        bus.cdbGrant = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.loadEnable = 1'b0;
        bus.addr_in    = '0;
        bus.robNum_in  = '0;
        bus.subType_in = '0;
        bus.flush      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.cdbGrant   = 1'b0;
        test_reset();
        test_lb_sign();
        test_lhu_zero_wait();
        test_lw_wait();
        test_flush_wait();
        test_grant_stall();
        test_invalid_tag();
        test_misalign();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
